x_ramb_asym_dp_int: RTL and testbench



---
 rtl/x_ramb_asym_dp_int_if.sv | 32 +++
 rtl/x_ramb_asym_dp_int.sv | 144 ++++++++++++++
 tb/tb_x_ramb_asym_dp_int.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/x_ramb_asym_dp_int_if.sv
// Port bundle for the asymmetric dual-port RAM model: per-port address, data, enables and
// read data, plus the collision flag.
interface x_ramb_asym_dp_int_if #(
  parameter int unsigned MEM_BITS = 4096,
  parameter int unsigned WIDTH_A  = 1,
  parameter int unsigned WIDTH_B  = 8
);
  localparam int unsigned AW_A = $clog2(MEM_BITS / WIDTH_A);
  localparam int unsigned AW_B = $clog2(MEM_BITS / WIDTH_B);

  logic [AW_A-1:0]    ADDRA;
  logic [WIDTH_A-1:0] DIA;
  logic               ENA;
  logic               WEA;
  logic [WIDTH_A-1:0] DOA;
  logic [AW_B-1:0]    ADDRB;
  logic [WIDTH_B-1:0] DIB;
  logic               ENB;
  logic               WEB;
  logic [WIDTH_B-1:0] DOB;
  logic               COLL;

  modport master (
    output ADDRA, DIA, ENA, WEA, ADDRB, DIB, ENB, WEB,
    input  DOA, DOB, COLL
  );

  modport slave (
    input  ADDRA, DIA, ENA, WEA, ADDRB, DIB, ENB, WEB,
    output DOA, DOB, COLL
  );
endinterface

// File: rtl/x_ramb_asym_dp_int.sv
// Behavioural single-clock true dual-port RAM with independent power-of-two port widths.
// Define X_RAMB_ASYM_DP_COLLCHK_EN to enable cross-port collision flagging and X-propagation.
module x_ramb_asym_dp_int #(
  parameter int unsigned         MEM_BITS     = 4096,
  parameter int unsigned         WIDTH_A      = 1,
  parameter int unsigned         WIDTH_B      = 8,
  parameter int unsigned         WRITE_MODE_A = 0,
  parameter int unsigned         WRITE_MODE_B = 0,
  parameter int unsigned         DO_REG       = 0,
  parameter logic [WIDTH_A-1:0]  SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0]  SRVAL_B      = '0,
  parameter logic [MEM_BITS-1:0] INIT         = '0
) (
  input logic                  CLKA,
  input logic                  RSTB,
  x_ramb_asym_dp_int_if.slave  bus
);
  localparam int unsigned MW   = $clog2(MEM_BITS);
  localparam int unsigned LW_A = $clog2(WIDTH_A);
  localparam int unsigned LW_B = $clog2(WIDTH_B);
  localparam int unsigned AW_A = $clog2(MEM_BITS / WIDTH_A);
  localparam int unsigned AW_B = $clog2(MEM_BITS / WIDTH_B);
  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;

  // Power-up image; reset never touches the array.
  logic [MEM_BITS-1:0] mem_q = INIT;

  logic [AW_A-1:0]    addra_c;
  logic [AW_B-1:0]    addrb_c;
  logic [MW-1:0]      a_lo_c;
  logic [MW-1:0]      b_lo_c;
  logic [WIDTH_A-1:0] rd_a_c;
  logic [WIDTH_B-1:0] rd_b_c;
  logic [WIDTH_A-1:0] doa1_d, doa1_q;
  logic [WIDTH_B-1:0] dob1_d, dob1_q;

`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
  localparam int unsigned LW_M = (LW_A > LW_B) ? LW_A : LW_B;
  logic ovl_c;
  logic coll_c;
  logic coll_q;
`endif

  // Word base bit index per port and the raw (pre-write) read words.
  always_comb begin
    addra_c = bus.ADDRA;
    addrb_c = bus.ADDRB;
    a_lo_c  = MW'(addra_c) << LW_A;
    b_lo_c  = MW'(addrb_c) << LW_B;
    rd_a_c  = mem_q[a_lo_c +: WIDTH_A];
    rd_b_c  = mem_q[b_lo_c +: WIDTH_B];
`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
    // Aligned power-of-two words overlap iff they share the wider word index.
    ovl_c  = ((a_lo_c >> LW_M) == (b_lo_c >> LW_M));
    coll_c = bus.ENA & bus.ENB & ovl_c & (bus.WEA | bus.WEB);
    if (coll_c && !bus.WEA) begin
      for (int i = 0; i < int'(WIDTH_A); i++) begin
        if (((a_lo_c + MW'(i)) >> LW_B) == (b_lo_c >> LW_B)) rd_a_c[i] = 1'bx;
      end
    end
    if (coll_c && !bus.WEB) begin
      for (int i = 0; i < int'(WIDTH_B); i++) begin
        if (((b_lo_c + MW'(i)) >> LW_A) == (a_lo_c >> LW_A)) rd_b_c[i] = 1'bx;
      end
    end
`endif
  end

  // Stage-1 next value: read, or write-mode dependent result on a write.
  always_comb begin
    doa1_d = doa1_q;
    dob1_d = dob1_q;
    if (bus.ENA) begin
      if (!bus.WEA)                        doa1_d = rd_a_c;
      else if (WRITE_MODE_A == WM_WRITE_FIRST) doa1_d = bus.DIA;
      else if (WRITE_MODE_A == WM_READ_FIRST)  doa1_d = rd_a_c;
    end
    if (bus.ENB) begin
      if (!bus.WEB)                        dob1_d = rd_b_c;
      else if (WRITE_MODE_B == WM_WRITE_FIRST) dob1_d = bus.DIB;
      else if (WRITE_MODE_B == WM_READ_FIRST)  dob1_d = rd_b_c;
    end
  end

  // Array update; the later port B assignment wins on overlapping bits.
  always_ff @(posedge CLKA) begin
    if (!RSTB) begin
      if (bus.ENA && bus.WEA) mem_q[a_lo_c +: WIDTH_A] <= bus.DIA;
      if (bus.ENB && bus.WEB) mem_q[b_lo_c +: WIDTH_B] <= bus.DIB;
`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
      if (coll_c && bus.WEA && bus.WEB) begin
        for (int i = 0; i < int'(WIDTH_A); i++) begin
          if (((a_lo_c + MW'(i)) >> LW_B) == (b_lo_c >> LW_B)) mem_q[a_lo_c + MW'(i)] <= 1'bx;
        end
      end
      if (coll_c) $display("%0t x_ramb_asym_dp_int: collision ADDRA=%0d ADDRB=%0d",
                           $time, addra_c, addrb_c);
`endif
    end
  end

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      doa1_q <= SRVAL_A;
      dob1_q <= SRVAL_B;
    end else begin
      doa1_q <= doa1_d;
      dob1_q <= dob1_d;
    end
  end

`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
  always_ff @(posedge CLKA) begin
    if (RSTB) coll_q <= 1'b0;
    else      coll_q <= coll_c;
  end
  assign bus.COLL = coll_q;
`else
  assign bus.COLL = 1'b0;
`endif

  // Optional output pipeline: stage 2 follows stage 1 every edge.
  generate
    if (DO_REG != 0) begin : g_oreg
      logic [WIDTH_A-1:0] doa2_q;
      logic [WIDTH_B-1:0] dob2_q;
      always_ff @(posedge CLKA) begin
        if (RSTB) begin
          doa2_q <= SRVAL_A;
          dob2_q <= SRVAL_B;
        end else begin
          doa2_q <= doa1_q;
          dob2_q <= dob1_q;
        end
      end
      assign bus.DOA = doa2_q;
      assign bus.DOB = dob2_q;
    end else begin : g_noreg
      assign bus.DOA = doa1_q;
      assign bus.DOB = dob1_q;
    end
  endgenerate
endmodule

// File: tb/tb_x_ramb_asym_dp_int.sv
// Directed bench: four RAM instances (B write-first, read-first, no-change, pipelined) share one
// stimulus stream; each is checked against hand-computed values.
module tb_x_ramb_asym_dp_int;
  logic        clk = 1'b0;
  logic        rstb;
  logic        ena, wea, dia, enb, web;
  logic [11:0] addra;
  logic [8:0]  addrb;
  logic [7:0]  dib;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  x_ramb_asym_dp_int_if bw ();
  x_ramb_asym_dp_int_if br ();
  x_ramb_asym_dp_int_if bn ();
  x_ramb_asym_dp_int_if bp ();

  assign bw.ENA = ena; assign bw.WEA = wea; assign bw.ADDRA = addra; assign bw.DIA = dia;
  assign bw.ENB = enb; assign bw.WEB = web; assign bw.ADDRB = addrb; assign bw.DIB = dib;
  assign br.ENA = ena; assign br.WEA = wea; assign br.ADDRA = addra; assign br.DIA = dia;
  assign br.ENB = enb; assign br.WEB = web; assign br.ADDRB = addrb; assign br.DIB = dib;
  assign bn.ENA = ena; assign bn.WEA = wea; assign bn.ADDRA = addra; assign bn.DIA = dia;
  assign bn.ENB = enb; assign bn.WEB = web; assign bn.ADDRB = addrb; assign bn.DIB = dib;
  assign bp.ENA = ena; assign bp.WEA = wea; assign bp.ADDRA = addra; assign bp.DIA = dia;
  assign bp.ENB = enb; assign bp.WEB = web; assign bp.ADDRB = addrb; assign bp.DIB = dib;

  x_ramb_asym_dp_int #(.WRITE_MODE_B(0), .SRVAL_B(8'hA5)) dut_wf (.CLKA(clk), .RSTB(rstb), .bus(bw));
  x_ramb_asym_dp_int #(.WRITE_MODE_B(1))                  dut_rf (.CLKA(clk), .RSTB(rstb), .bus(br));
  x_ramb_asym_dp_int #(.WRITE_MODE_B(2))                  dut_nc (.CLKA(clk), .RSTB(rstb), .bus(bn));
  x_ramb_asym_dp_int #(.DO_REG(1), .SRVAL_B(8'hA5))       dut_pr (.CLKA(clk), .RSTB(rstb), .bus(bp));

  typedef struct {
    logic        ena, wea;
    logic [11:0] addra;
    logic        dia;
    logic        enb, web;
    logic [8:0]  addrb;
    logic [7:0]  dib;
    logic        exp_doa;
    logic [7:0]  exp_wf, exp_rf, exp_nc;
  } vec_t;

  function automatic vec_t mk(logic ea, logic wa, logic [11:0] aa, logic da, logic eb, logic wb,
                              logic [8:0] ab, logic [7:0] db, logic xa, logic [7:0] xw,
                              logic [7:0] xr, logic [7:0] xn);
    vec_t v;
    v.ena = ea; v.wea = wa; v.addra = aa; v.dia = da;
    v.enb = eb; v.web = wb; v.addrb = ab; v.dib = db;
    v.exp_doa = xa; v.exp_wf = xw; v.exp_rf = xr; v.exp_nc = xn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [11:0] aa, input logic da,
                       input logic eb, input logic wb, input logic [8:0] ab, input logic [7:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 9'd0, 8'h00);
  endtask

  vec_t       vecs[13];
  logic       prev_doa;
  logic [7:0] prev_dob;

  initial begin
    // Width mapping, then B-port write modes with a prior nonzero read for NO_CHANGE.
    vecs[0]  = mk(0, 0, 12'd0,  0, 1, 1, 9'd3, 8'h81, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[1]  = mk(1, 0, 12'd24, 0, 0, 0, 9'd0, 8'h00, 1'b1, 8'h81, 8'h00, 8'h00);
    vecs[2]  = mk(1, 0, 12'd25, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[3]  = mk(1, 0, 12'd26, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[4]  = mk(1, 0, 12'd27, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[5]  = mk(1, 0, 12'd28, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[6]  = mk(1, 0, 12'd29, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[7]  = mk(1, 0, 12'd30, 0, 0, 0, 9'd0, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00);
    vecs[8]  = mk(1, 0, 12'd31, 0, 0, 0, 9'd0, 8'h00, 1'b1, 8'h81, 8'h00, 8'h00);
    vecs[9]  = mk(0, 0, 12'd0,  0, 1, 0, 9'd3, 8'h00, 1'b1, 8'h81, 8'h81, 8'h81);
    vecs[10] = mk(0, 0, 12'd0,  0, 1, 1, 9'd5, 8'h11, 1'b1, 8'h11, 8'h00, 8'h81);
    vecs[11] = mk(0, 0, 12'd0,  0, 1, 1, 9'd5, 8'h22, 1'b1, 8'h22, 8'h11, 8'h81);
    vecs[12] = mk(0, 0, 12'd0,  0, 1, 0, 9'd5, 8'h00, 1'b1, 8'h22, 8'h22, 8'h22);

    rstb = 1'b1;
    idle();
    chk("rst_wf_dob", 32'(bw.DOB), 32'h0000_00A5);
    chk("rst_wf_doa", 32'(bw.DOA), 32'h0);
    chk("rst_wf_coll", 32'(bw.COLL), 32'h0);
    chk("rst_rf_dob", 32'(br.DOB), 32'h0);
    chk("rst_pr_dob", 32'(bp.DOB), 32'h0000_00A5);
    rstb = 1'b0;

    // Table: the pipelined instance (B write-first) lags the write-first one by one edge.
    prev_doa = 1'b0;
    prev_dob = 8'hA5;
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].ena, vecs[k].wea, vecs[k].addra, vecs[k].dia,
            vecs[k].enb, vecs[k].web, vecs[k].addrb, vecs[k].dib);
      chk($sformatf("vec%0d_doa", k), 32'(bw.DOA), 32'(vecs[k].exp_doa));
      chk($sformatf("vec%0d_wf", k), 32'(bw.DOB), 32'(vecs[k].exp_wf));
      chk($sformatf("vec%0d_rf", k), 32'(br.DOB), 32'(vecs[k].exp_rf));
      chk($sformatf("vec%0d_nc", k), 32'(bn.DOB), 32'(vecs[k].exp_nc));
      chk($sformatf("vec%0d_pr_doa", k), 32'(bp.DOA), 32'(prev_doa));
      chk($sformatf("vec%0d_pr_dob", k), 32'(bp.DOB), 32'(prev_dob));
      prev_doa = vecs[k].exp_doa;
      prev_dob = vecs[k].exp_wf;
    end

    // A writes bit 40 while B reads word 5 (bits 40..47).
    drive(0, 0, 12'd0, 0, 1, 1, 9'd5, 8'h00);
    chk("coll_prep", 32'(bw.DOB), 32'h0);
    drive(1, 1, 12'd40, 1, 1, 0, 9'd5, 8'h00);
    chk("coll_doa", 32'(bw.DOA), 32'h1);
`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
    chk("coll_flag", 32'(bw.COLL), 32'h1);
    chk("coll_dob_hi", 32'(bw.DOB[7:1]), 32'h0);
`else
    chk("coll_flag", 32'(bw.COLL), 32'h0);
    chk("coll_dob", 32'(bw.DOB), 32'h0);
`endif
    idle();
    chk("coll_clear", 32'(bw.COLL), 32'h0);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd5, 8'h00);
    chk("coll_after", 32'(bw.DOB), 32'h01);

    // Both ports write bit 40: B's 1 must beat A's 0.
    drive(1, 1, 12'd40, 0, 1, 1, 9'd5, 8'hFF);
    chk("ww_dob", 32'(bw.DOB), 32'hFF);
`ifdef X_RAMB_ASYM_DP_COLLCHK_EN
    chk("ww_flag", 32'(bw.COLL), 32'h1);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd5, 8'h00);
    chk("ww_read_hi", 32'(bw.DOB[7:1]), 32'h7F);
`else
    chk("ww_flag", 32'(bw.COLL), 32'h0);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd5, 8'h00);
    chk("ww_read_b", 32'(bw.DOB), 32'hFF);
    drive(1, 0, 12'd40, 0, 0, 0, 9'd0, 8'h00);
    chk("ww_read_a", 32'(bw.DOA), 32'h1);
`endif

    // Pipelined read of the top B word, then reset in the pipeline gap.
    drive(0, 0, 12'd0, 0, 1, 1, 9'd511, 8'h5A);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd0, 8'h00);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd511, 8'h00);
    chk("pr_lat1", 32'(bp.DOB), 32'h00);
    chk("wf_top", 32'(bw.DOB), 32'h5A);
    idle();
    chk("pr_lat2", 32'(bp.DOB), 32'h5A);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd3, 8'h00);
    chk("pr_gap_pre", 32'(bp.DOB), 32'h5A);
    rstb = 1'b1;
    idle();
    chk("pr_gap_rst", 32'(bp.DOB), 32'hA5);
    chk("wf_gap_rst", 32'(bw.DOB), 32'hA5);
    rstb = 1'b0;
    idle();
    chk("pr_gap_lost", 32'(bp.DOB), 32'hA5);

    // Write to the top A bit under reset must be dropped.
    rstb = 1'b1;
    drive(1, 1, 12'd4095, 1, 0, 0, 9'd0, 8'h00);
    chk("rw_doa_rst", 32'(bw.DOA), 32'h0);
    rstb = 1'b0;
    drive(1, 0, 12'd4095, 0, 0, 0, 9'd0, 8'h00);
    chk("rw_init_bit", 32'(bw.DOA), 32'h0);
    drive(1, 1, 12'd4095, 1, 0, 0, 9'd0, 8'h00);
    chk("rw_top_wr", 32'(bw.DOA), 32'h1);
    drive(0, 0, 12'd0, 0, 1, 0, 9'd511, 8'h00);
    chk("rw_top_b", 32'(bw.DOB), 32'hDA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
